fifo_rd_arbiter: RTL and testbench
==================================

Name: fifo_rd_arbiter

Overview:
- Round-robin arbiter that shares the read port of the async FIFO's read domain between NUM_REQ consumers.
- Drives the read-side `rinc` and samples `rempty` and the FIFO read data (async memory read at `raddr`).
- Grants one consumer at a time for a burst of up to BURST_LEN words, then forwards each popped word tagged with the consumer's ID.
- Sits entirely in the read clock domain, between the FIFO read controller/memory and the consumers.

Parameters:
- NUM_REQ, 4, number of consumers (2..16).
- DATA_WIDTH, 8, FIFO word width.
- BURST_LEN, 4, maximum pops per grant (1..255).
- TIMEOUT_CYCLES, 8, consecutive empty cycles before a forced release; used only with RD_ARB_TIMEOUT_EN.

Ports:
- r_clk  input  1  read-domain clock.
- r_rst  input  1  asynchronous, active-high reset.
- rempty  input  1  FIFO empty flag.
- rdata  input  DATA_WIDTH  FIFO read data; valid whenever rempty=0.
- rinc  output  1  FIFO pop strobe.
- req  input  NUM_REQ  per-consumer read request; level-sensitive.
- gnt  output  NUM_REQ  one-hot grant, registered.
- dout  output  DATA_WIDTH  registered popped word.
- dout_valid  output  1  one-cycle strobe; dout is valid.
- dout_id  output  clog2(NUM_REQ)  index of the consumer owning dout.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (asynchronous, r_rst=1):
  - State IDLE; gnt=0, rinc=0, dout=0, dout_valid=0, dout_id=0, busy=0.
  - Burst count=0; last_owner=NUM_REQ-1, so consumer 0 has first priority.
  - Reset mid-burst aborts immediately. No pop occurs in the reset cycle.
- State IDLE:
  - If |req, select the first asserted req scanning from last_owner+1 with wrap-around.
  - Load gnt with that one-hot value, clear the count, and go to GRANT on the next edge.
  - Arbitration costs exactly 1 cycle; no pop happens in IDLE.
- State GRANT:
  - rinc = req[owner] & ~rempty, combinational. Never assert rinc when rempty=1.
  - On each pop: count+1; dout<=rdata and dout_id<=owner on the same edge; dout_valid=1 the following cycle. Read latency is 1 cycle from the rinc edge.
  - Exit to IDLE (gnt<=0, last_owner<=owner) when either:
    - a pop makes count==BURST_LEN; or
    - req[owner]=0 at a clock edge.
  - The exit is registered, so the next arbitration starts the cycle after the exit.
  - rempty=1 with req[owner]=1: hold the grant, no pop, count unchanged.
- Requests from non-owners are ignored during GRANT.
- A requester whose req rises while another owns the grant waits for the round-robin turn. No starvation: every requester is served within NUM_REQ grants.
- Count width: clog2(BURST_LEN+1) bits. It never wraps, because the burst exits at BURST_LEN.
- busy = (state==GRANT). gnt is never multi-hot.
- dout_valid is a single-cycle pulse per pop; back-to-back pops give a continuous dout_valid.

Optional Feature:
- Macro RD_ARB_TIMEOUT_EN.
- When defined:
  - An empty-wait counter (clog2(TIMEOUT_CYCLES+1) bits) increments each GRANT cycle with rempty=1 and req[owner]=1, and clears on any pop.
  - When it reaches TIMEOUT_CYCLES, the grant is released to IDLE as if the burst completed (last_owner<=owner).
  - Counter reset value is 0.
- When undefined: no counter; an owner waiting on an empty FIFO holds the grant indefinitely.

Test Plan:
- Reset with FIFO holding 3 words, req=0 -> gnt=0, rinc=0, dout_valid=0; release reset, no pops occur.
- req=4'b0001, FIFO holds 6 words (BURST_LEN=4) -> gnt=0001 one cycle after req; rinc high 4 consecutive cycles; dout_valid for words 0..3 with dout_id=0; then IDLE and re-grant to 0 with 2 more words.
- req=4'b1111, FIFO holds 16 words -> grant order 0,1,2,3, each with 4 pops, then 0 again; dout_id sequence 0000 1111 2222 3333.
- Owner 2 granted, FIFO holds 1 word, req[2] held -> 1 pop, then rinc=0 while rempty=1; no dout_valid until a new write makes rempty=0, then the pop resumes under the same grant. With RD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant released after 8 empty cycles, and pending req[3] is granted next.
- Owner 1 drops req after 2 of 4 pops -> exit to IDLE after exactly 2 pops; next grant goes to the lowest pending index above 1 with wrap-around.
- Assert r_rst mid-burst, after 2 pops -> gnt, rinc, dout_valid and busy go 0 asynchronously; after release, consumer 0 wins first.

Source files
------------

// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the async FIFO read domain, the round-robin arbiter and its consumers.
interface fifo_rd_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [IdW-1:0]        dout_id;
    logic                  busy;

    modport master (
        input  rempty, rdata, req,
        output rinc, gnt, dout, dout_valid, dout_id, busy
    );

    modport slave (
        output rempty, rdata, req,
        input  rinc, gnt, dout, dout_valid, dout_id, busy
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NUM_REQ consumers in bursts.
// Optional empty-wait grant release is enabled by defining RD_ARB_TIMEOUT_EN.
module fifo_rd_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input logic                r_clk,
    input logic                r_rst,
    fifo_rd_arbiter_if.master  bus
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1 || BURST_LEN > 255 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("fifo_rd_arbiter: parameter out of range");
    end

    typedef enum logic {StIdle, StGrant} state_e;

    state_e                r_state, w_state_nxt;
    logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
    logic [IdW-1:0]        r_owner, w_owner_nxt;
    logic [IdW-1:0]        r_last_owner, w_last_owner_nxt;
    logic [CntW-1:0]       r_count, w_count_nxt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic [IdW-1:0]        r_dout_id;

    logic           w_owner_req;
    logic           w_rinc;
    logic           w_burst_done;
    logic           w_timeout;
    logic           w_found;
    logic [IdW-1:0] w_sel;
    logic [IdW-1:0] w_idx;

    assign w_owner_req  = bus.req[r_owner];
    assign w_rinc       = (r_state == StGrant) && w_owner_req && !bus.rempty;
    assign w_burst_done = w_rinc && (r_count == CntW'(BURST_LEN - 1));

`ifdef RD_ARB_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WaitW-1:0] r_wait, w_wait_nxt;

    // Counts only cycles where the owner is stalled on an empty FIFO; any pop or idle clears it.
    always_comb begin
        w_wait_nxt = '0;
        if (r_state == StGrant && w_owner_req && bus.rempty) begin
            w_wait_nxt = r_wait + 1'b1;
        end
    end

    assign w_timeout = (w_wait_nxt == WaitW'(TIMEOUT_CYCLES));

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // First asserted request scanning upward from the previous owner, with wrap-around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_idx = IdW'((32'(r_last_owner) + i) % NUM_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_count_nxt      = r_count;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_nxt        = StGrant;
                    w_gnt_nxt          = '0;
                    w_gnt_nxt[w_sel]   = 1'b1;
                    w_owner_nxt        = w_sel;
                    w_count_nxt        = '0;
                end
            end
            StGrant: begin
                if (w_rinc) begin
                    w_count_nxt = r_count + 1'b1;
                end
                if (w_burst_done || !w_owner_req || w_timeout) begin
                    w_state_nxt      = StIdle;
                    w_gnt_nxt        = '0;
                    w_last_owner_nxt = r_owner;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_state      <= StIdle;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= IdW'(NUM_REQ - 1);
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_id    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_count      <= w_count_nxt;
            r_dout_valid <= w_rinc;
            if (w_rinc) begin
                r_dout    <= bus.rdata;
                r_dout_id <= r_owner;
            end
        end
    end

    assign bus.rinc       = w_rinc;
    assign bus.gnt        = r_gnt;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_id    = r_dout_id;
    assign bus.busy       = (r_state == StGrant);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: 4 consumers, burst of 4, behavioural FIFO read side.
module tb_fifo_rd_arbiter;
    logic r_clk = 1'b0;
    logic r_rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 r_clk = ~r_clk;

    fifo_rd_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_rd_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .BURST_LEN(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .r_clk(r_clk),
        .r_rst(r_rst),
        .bus(bus)
    );

    // Behavioural FIFO: words appear at rdata while rd_ptr != wr_ptr, pop on rinc.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.rempty = (rd_ptr == wr_ptr);
    assign bus.rdata  = mem[rd_ptr[5:0]];

    always @(posedge r_clk) begin
        if (bus.rinc) begin
            vectors++;
            if (bus.rempty) begin
                miscompares++;
                $display("FAIL rinc_while_empty at %0t: rinc=1 rempty=1, want rinc=0", $time);
            end else begin
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr++;
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       rinc;
        logic       dv;
        logic [7:0] dout;
        logic [1:0] id;
    } vec_t;

    function automatic vec_t v(input int rq, input int g, input int ri, input int d, input int o,
                               input int id);
        return '{4'(rq), 4'(g), 1'(ri), 1'(d), 8'(o), 2'(id)};
    endfunction

    task automatic pulse_reset();
        @(negedge r_clk);
        r_rst = 1'b1;
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        bus.req = 4'h0;
        r_rst   = 1'b1;
        push(8'h10);
        push(8'h11);
        push(8'h12);
        repeat (2) @(negedge r_clk);
        #1;
        got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
        vectors++;
        if (got !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want %h", got, 17'h0);
        end
        @(negedge r_clk);
        r_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk);
            #1;
            got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
            vectors++;
            if (got !== 17'h0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d] got %h want %h", i, got, 17'h0);
            end
        end
        vectors++;
        if (rd_ptr !== 0) begin
            miscompares++;
            $display("FAIL reset_no_pop got pops=%0d want 0", rd_ptr);
        end
    endtask

    task automatic test_basic();
        vec_t t[$];
        logic [16:0] got, exp;
        push(8'h13);
        push(8'h14);
        push(8'h15);
        t = '{v('h1, 'h0, 0, 0, 'h00, 0), v('h1, 'h1, 1, 0, 'h00, 0), v('h1, 'h1, 1, 1, 'h10, 0),
              v('h1, 'h1, 1, 1, 'h11, 0), v('h1, 'h1, 1, 1, 'h12, 0), v('h1, 'h0, 0, 1, 'h13, 0),
              v('h1, 'h1, 1, 0, 'h13, 0), v('h1, 'h1, 1, 1, 'h14, 0), v('h1, 'h1, 0, 1, 'h15, 0),
              v('h0, 'h1, 0, 0, 'h15, 0), v('h0, 'h0, 0, 0, 'h15, 0)};
        for (int i = 0; i < t.size(); i++) begin
            @(negedge r_clk);
            bus.req = t[i].req;
            #1;
            got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
            exp = {t[i].gnt, |t[i].gnt, t[i].rinc, t[i].dv, t[i].dout, t[i].id};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL basic[%0d] gnt/busy/rinc/dv/dout/id got %h/%b/%b/%b/%h/%0d want %h/%b/%b/%b/%h/%0d",
                         i, got[16:13], got[12], got[11], got[10], got[9:2], got[1:0],
                         exp[16:13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
            end
        end
    endtask

    task automatic test_all_req();
        vec_t t[$];
        logic [16:0] got, exp;
        pulse_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        t = '{v('hF, 'h0, 0, 0, 'h00, 0), v('hF, 'h1, 1, 0, 'h00, 0), v('hF, 'h1, 1, 1, 'h20, 0),
              v('hF, 'h1, 1, 1, 'h21, 0), v('hF, 'h1, 1, 1, 'h22, 0), v('hF, 'h0, 0, 1, 'h23, 0),
              v('hF, 'h2, 1, 0, 'h23, 0), v('hF, 'h2, 1, 1, 'h24, 1), v('hF, 'h2, 1, 1, 'h25, 1),
              v('hF, 'h2, 1, 1, 'h26, 1), v('hF, 'h0, 0, 1, 'h27, 1), v('hF, 'h4, 1, 0, 'h27, 1),
              v('hF, 'h4, 1, 1, 'h28, 2), v('hF, 'h4, 1, 1, 'h29, 2), v('hF, 'h4, 1, 1, 'h2A, 2),
              v('hF, 'h0, 0, 1, 'h2B, 2), v('hF, 'h8, 1, 0, 'h2B, 2), v('hF, 'h8, 1, 1, 'h2C, 3),
              v('hF, 'h8, 1, 1, 'h2D, 3), v('hF, 'h8, 1, 1, 'h2E, 3), v('hF, 'h0, 0, 1, 'h2F, 3),
              v('hF, 'h1, 0, 0, 'h2F, 3), v('h0, 'h1, 0, 0, 'h2F, 3), v('h0, 'h0, 0, 0, 'h2F, 3)};
        for (int i = 0; i < t.size(); i++) begin
            @(negedge r_clk);
            bus.req = t[i].req;
            #1;
            got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
            exp = {t[i].gnt, |t[i].gnt, t[i].rinc, t[i].dv, t[i].dout, t[i].id};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL all_req[%0d] gnt/busy/rinc/dv/dout/id got %h/%b/%b/%b/%h/%0d want %h/%b/%b/%b/%h/%0d",
                         i, got[16:13], got[12], got[11], got[10], got[9:2], got[1:0],
                         exp[16:13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
            end
        end
    endtask

    task automatic test_empty_hold();
        vec_t t[$];
        logic [16:0] got, exp;
        int push_row;
        push(8'h30);
`ifdef RD_ARB_TIMEOUT_EN
        push_row = 12;
        t = '{v('h4, 'h0, 0, 0, 'h2F, 3), v('h4, 'h4, 1, 0, 'h2F, 3), v('hC, 'h4, 0, 1, 'h30, 2),
              v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2),
              v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2),
              v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h0, 0, 0, 'h30, 2), v('hC, 'h8, 0, 0, 'h30, 2),
              v('hC, 'h8, 1, 0, 'h30, 2), v('h0, 'h8, 0, 1, 'h31, 3), v('h0, 'h0, 0, 0, 'h31, 3)};
`else
        push_row = 11;
        t = '{v('h4, 'h0, 0, 0, 'h2F, 3), v('h4, 'h4, 1, 0, 'h2F, 3), v('hC, 'h4, 0, 1, 'h30, 2),
              v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2),
              v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2),
              v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 0, 0, 'h30, 2), v('hC, 'h4, 1, 0, 'h30, 2),
              v('hC, 'h4, 0, 1, 'h31, 2), v('h0, 'h4, 0, 0, 'h31, 2), v('h0, 'h0, 0, 0, 'h31, 2)};
`endif
        for (int i = 0; i < t.size(); i++) begin
            @(negedge r_clk);
            bus.req = t[i].req;
            if (i == push_row) push(8'h31);
            #1;
            got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
            exp = {t[i].gnt, |t[i].gnt, t[i].rinc, t[i].dv, t[i].dout, t[i].id};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL empty_hold[%0d] gnt/busy/rinc/dv/dout/id got %h/%b/%b/%b/%h/%0d want %h/%b/%b/%b/%h/%0d",
                         i, got[16:13], got[12], got[11], got[10], got[9:2], got[1:0],
                         exp[16:13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
            end
        end
    endtask

    task automatic test_req_drop();
        vec_t t[$];
        logic [16:0] got, exp;
        pulse_reset();
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        t = '{v('h2, 'h0, 0, 0, 'h00, 0), v('hB, 'h2, 1, 0, 'h00, 0), v('hB, 'h2, 1, 1, 'h40, 1),
              v('h9, 'h2, 0, 1, 'h41, 1), v('h9, 'h0, 0, 0, 'h41, 1), v('h9, 'h8, 1, 0, 'h41, 1),
              v('h0, 'h8, 0, 1, 'h42, 3), v('h0, 'h0, 0, 0, 'h42, 3)};
        for (int i = 0; i < t.size(); i++) begin
            @(negedge r_clk);
            bus.req = t[i].req;
            #1;
            got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
            exp = {t[i].gnt, |t[i].gnt, t[i].rinc, t[i].dv, t[i].dout, t[i].id};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL req_drop[%0d] gnt/busy/rinc/dv/dout/id got %h/%b/%b/%b/%h/%0d want %h/%b/%b/%b/%h/%0d",
                         i, got[16:13], got[12], got[11], got[10], got[9:2], got[1:0],
                         exp[16:13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
            end
        end
    endtask

    task automatic test_mid_burst_reset();
        vec_t t[$];
        logic [16:0] got, exp;
        int start_ptr;
        start_ptr = rd_ptr;
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        t = '{v('h4, 'h0, 0, 0, 'h42, 3), v('h4, 'h4, 1, 0, 'h42, 3), v('h4, 'h4, 1, 1, 'h43, 2),
              v('h4, 'h0, 0, 0, 'h00, 0), v('hF, 'h0, 0, 0, 'h00, 0), v('hF, 'h0, 0, 0, 'h00, 0),
              v('hF, 'h1, 1, 0, 'h00, 0), v('h0, 'h1, 0, 1, 'h51, 0), v('h0, 'h0, 0, 0, 'h51, 0)};
        for (int i = 0; i < t.size(); i++) begin
            @(negedge r_clk);
            bus.req = t[i].req;
            if (i == 3) r_rst = 1'b1;
            if (i == 5) r_rst = 1'b0;
            #1;
            got = {bus.gnt, bus.busy, bus.rinc, bus.dout_valid, bus.dout, bus.dout_id};
            exp = {t[i].gnt, |t[i].gnt, t[i].rinc, t[i].dv, t[i].dout, t[i].id};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL mid_reset[%0d] gnt/busy/rinc/dv/dout/id got %h/%b/%b/%b/%h/%0d want %h/%b/%b/%b/%h/%0d",
                         i, got[16:13], got[12], got[11], got[10], got[9:2], got[1:0],
                         exp[16:13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
            end
        end
        vectors++;
        if (rd_ptr - start_ptr !== 3) begin
            miscompares++;
            $display("FAIL mid_reset_pops got %0d want 3", rd_ptr - start_ptr);
        end
    endtask

    initial begin
        bus.req = 4'h0;
        test_reset();
        test_basic();
        test_all_req();
        test_empty_hold();
        test_req_drop();
        test_mid_burst_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
